// File: rtl/mem_stage_lsu_pkg.sv
// lsu_defs: shared funct3 codes, FSM state encoding and access-size helpers for the MEM-stage LSU.
package lsu_defs;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_DONE = 2'd2} lsu_state_t;
    typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2} lsu_size_t;

    // Undefined width codes fall through to a word access.
    function automatic lsu_size_t access_size(input logic [2:0] f3);
        return (f3 == F3_LB || f3 == F3_LBU) ? SZ_BYTE :
               (f3 == F3_LH || f3 == F3_LHU) ? SZ_HALF : SZ_WORD;
    endfunction

    function automatic logic is_misaligned(input lsu_size_t sz, input logic [1:0] off);
        return (sz == SZ_HALF && off[0]) || (sz == SZ_WORD && off != 2'b00);
    endfunction

    function automatic logic [1:0] align_offset(input lsu_size_t sz, input logic [1:0] off);
        return (sz == SZ_HALF) ? {off[1], 1'b0} : (sz == SZ_WORD) ? 2'b00 : off;
    endfunction

endpackage

// File: rtl/load_formatter.sv
// load_formatter: selects the addressed byte/half of a read word and sign- or zero-extends it.
module load_formatter
    import lsu_defs::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    output logic [31:0] data
);
    lsu_size_t   sz;
    logic [7:0]  b;
    logic [15:0] h;
    logic        sext;

    always_comb begin
        sz   = access_size(funct3);
        b    = rdata[{offset, 3'b000} +: 8];
        h    = offset[1] ? rdata[31:16] : rdata[15:0];
        sext = ~funct3[2];
        data = (sz == SZ_BYTE) ? {{24{b[7] & sext}}, b} :
               (sz == SZ_HALF) ? {{16{h[15] & sext}}, h} : rdata;
    end
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit with a single req/ack data-memory transaction and pipeline stall.
// MISALIGN_TRAP_EN: when defined, misaligned accesses are flagged and dropped instead of aligned down.
module mem_stage_lsu
    import lsu_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_mem_load,
    input  logic        ex_mem_store,
    input  logic [2:0]  ex_mem_funct3,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_mem_store_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] mem_read_data,
    output logic        lsu_stall,
    output logic        misalign
);
    lsu_state_t  state, state_nx;
    lsu_size_t   sz;
    logic        access, trap, issue;
    logic [1:0]  off;
    logic [3:0]  be_nx;
    logic [31:0] wdata_nx, fmt_data;

    always_comb begin
        access = ex_mem_load | ex_mem_store;
        sz     = access_size(ex_mem_funct3);
`ifdef MISALIGN_TRAP_EN
        trap   = access & is_misaligned(sz, ex_mem_addr[1:0]);
        off    = ex_mem_addr[1:0];
`else
        trap   = 1'b0;
        off    = align_offset(sz, ex_mem_addr[1:0]);
`endif
        issue    = (state == S_IDLE) & access & ~trap;
        be_nx    = (sz == SZ_BYTE) ? 4'b0001 << off :
                   (sz == SZ_HALF) ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata_nx = (sz == SZ_BYTE) ? {4{ex_mem_store_data[7:0]}} :
                   (sz == SZ_HALF) ? {2{ex_mem_store_data[15:0]}} : ex_mem_store_data;
        state_nx = issue ? S_REQ :
                   (state == S_REQ) ? (dmem_ack ? S_DONE : S_REQ) : S_IDLE;
        // Gated by rst so the pipeline is released the instant reset hits.
        lsu_stall = ~rst & (issue | (state == S_REQ));
        misalign  = ~rst & (state == S_IDLE) & trap;
    end

    load_formatter u_fmt (
        .funct3 (ex_mem_funct3),
        .offset (off),
        .rdata  (dmem_rdata),
        .data   (fmt_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            dmem_be       <= '0;
            mem_read_data <= '0;
        end else begin
            state <= state_nx;
            if (issue) begin
                dmem_req   <= 1'b1;
                dmem_we    <= ex_mem_store;
                dmem_addr  <= {ex_mem_addr[31:2], 2'b00};
                dmem_be    <= ex_mem_store ? be_nx : 4'b0000;
                dmem_wdata <= wdata_nx;
            end else if (state == S_REQ && dmem_ack) begin
                dmem_req <= 1'b0;
                if (ex_mem_load) mem_read_data <= fmt_data;
            end
            if (misalign) mem_read_data <= '0;
        end
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed transactions checked every cycle against a transaction-level model of the LSU.
module tb_mem_stage_lsu;
    logic        clk = 0, rst = 1;
    logic        ex_mem_load = 0, ex_mem_store = 0;
    logic [2:0]  ex_mem_funct3 = 0;
    logic [31:0] ex_mem_addr = 0, ex_mem_store_data = 0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack = 0;
    logic [31:0] dmem_rdata = 0;
    logic [31:0] mem_read_data;
    logic        lsu_stall, misalign;

    int n_chk = 0, n_err = 0;
    logic        chk_en = 1;
    logic        e_stall = 0, e_req = 0, e_mis = 0, e_we = 0;
    logic [31:0] e_addr = 0, e_wdata = 0, e_mrd = 0;
    logic [3:0]  e_be = 0;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;

    mem_stage_lsu dut (
        .clk(clk), .rst(rst),
        .ex_mem_load(ex_mem_load), .ex_mem_store(ex_mem_store),
        .ex_mem_funct3(ex_mem_funct3), .ex_mem_addr(ex_mem_addr),
        .ex_mem_store_data(ex_mem_store_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .mem_read_data(mem_read_data), .lsu_stall(lsu_stall), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_size(input logic [2:0] f3);
        return (f3 == 0 || f3 == 4) ? 1 : (f3 == 1 || f3 == 5) ? 2 : 4;
    endfunction

    function automatic int m_off(input logic [2:0] f3, input logic [31:0] a);
        return ((a % 4) / m_size(f3)) * m_size(f3);
    endfunction

    function automatic logic m_mis(input logic [2:0] f3, input logic [31:0] a);
        return (a % m_size(f3)) != 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        int n;
        n = m_size(f3);
        if (n == 4) return rd;
        v = (rd >> (8 * m_off(f3, a))) & ((n == 1) ? 32'hFF : 32'hFFFF);
        if (f3[2] == 0 && v >= ((n == 1) ? 32'd128 : 32'd32768))
            v = v - ((n == 1) ? 32'd256 : 32'd65536);
        return v;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int n;
        n = m_size(f3);
        return (n == 4) ? 4'hF : (((n == 1) ? 4'h1 : 4'h3) << m_off(f3, a));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
        int n;
        n = m_size(f3);
        return (n == 1) ? (sd & 32'hFF) * 32'h01010101 :
               (n == 2) ? (sd & 32'hFFFF) * 32'h00010001 : sd;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("lsu_stall", {31'd0, lsu_stall}, {31'd0, e_stall});
            chk("dmem_req", {31'd0, dmem_req}, {31'd0, e_req});
            chk("misalign", {31'd0, misalign}, {31'd0, e_mis});
            chk("mem_read_data", mem_read_data, e_mrd);
            if (e_req) begin
                chk("dmem_we", {31'd0, dmem_we}, {31'd0, e_we});
                chk("dmem_addr", dmem_addr, e_addr);
                chk("dmem_be", {28'd0, dmem_be}, {28'd0, e_be});
                if (e_we) chk("dmem_wdata", dmem_wdata, e_wdata);
            end
        end
    end

    task automatic idle(input logic ack);
        @(posedge clk); #1;
        ex_mem_load = 0; ex_mem_store = 0; dmem_ack = ack; dmem_rdata = 32'h13579BDF;
        e_stall = 0; e_req = 0; e_mis = 0;
    endtask

    task automatic access(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd, input int w);
        @(posedge clk); #1;
        ex_mem_load = ld; ex_mem_store = st; ex_mem_funct3 = f3;
        ex_mem_addr = a; ex_mem_store_data = sd; dmem_ack = 0;
        e_stall = 1; e_req = 0; e_mis = 0;
        e_we = st; e_addr = a & ~32'd3; e_be = st ? m_be(f3, a) : 4'h0; e_wdata = m_wdata(f3, sd);
        for (int i = 0; i <= w; i++) begin
            @(posedge clk); #1;
            e_req = 1;
            dmem_ack = (i == w);
            dmem_rdata = (i == w) ? rd : 32'h5A5A0000 + i;
            if (i == 0) begin
                cap_addr = dmem_addr; cap_be = dmem_be; cap_wdata = dmem_wdata; cap_we = dmem_we;
            end
        end
        @(posedge clk); #1;
        dmem_ack = 0; dmem_rdata = 32'hFFFFFFFF;
        e_stall = 0; e_req = 0;
        if (ld) e_mrd = m_load(f3, a, rd);
    endtask

    task automatic trap_access(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a);
        @(posedge clk); #1;
        ex_mem_load = ld; ex_mem_store = st; ex_mem_funct3 = f3; ex_mem_addr = a;
        e_stall = 0; e_req = 0; e_mis = 1;
        @(posedge clk); #1;
        ex_mem_load = 0; ex_mem_store = 0;
        e_mis = 0; e_mrd = 0;
    endtask

    task automatic go(input logic ld, input logic st, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd, input int w);
`ifdef MISALIGN_TRAP_EN
        if (m_mis(f3, a)) trap_access(ld, st, f3, a);
        else access(ld, st, f3, a, sd, rd, w);
`else
        access(ld, st, f3, a, sd, rd, w);
`endif
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 0;
        go(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0);
        chk("lw_result", mem_read_data, 32'hDEADBEEF);
        chk("lw_addr", cap_addr, 32'h100);
        chk("lw_be", {28'd0, cap_be}, 32'h0);
        go(1, 0, 3'b000, 32'h103, 0, 32'h80112233, 0);
        chk("lb_result", mem_read_data, 32'hFFFFFF80);
        go(1, 0, 3'b100, 32'h103, 0, 32'h80112233, 0);
        chk("lbu_result", mem_read_data, 32'h00000080);
        go(1, 0, 3'b101, 32'h102, 0, 32'h80112233, 1);
        chk("lhu_result", mem_read_data, 32'h00008011);
        go(1, 0, 3'b001, 32'h102, 0, 32'h80112233, 0);
        chk("lh_result", mem_read_data, 32'hFFFF8011);
        idle(0);
        go(0, 1, 3'b000, 32'h201, 32'h000000A5, 0, 0);
        chk("sb_be", {28'd0, cap_be}, 32'h2);
        chk("sb_wdata", cap_wdata, 32'hA5A5A5A5);
        chk("sb_we", {31'd0, cap_we}, 32'h1);
        chk("store_keeps_result", mem_read_data, 32'hFFFF8011);
        go(0, 1, 3'b001, 32'h202, 32'h1234BEEF, 0, 0);
        chk("sh_be", {28'd0, cap_be}, 32'hC);
        chk("sh_wdata", cap_wdata, 32'hBEEFBEEF);
        go(0, 1, 3'b010, 32'h204, 32'hCAFEF00D, 0, 2);
        chk("sw_be", {28'd0, cap_be}, 32'hF);
        idle(1);
        idle(0);
        go(1, 0, 3'b010, 32'h104, 0, 32'h0BADF00D, 3);
        chk("lw_wait_result", mem_read_data, 32'h0BADF00D);
        go(1, 0, 3'b011, 32'h108, 0, 32'h89ABCDEF, 0);
        chk("other_f3_word", mem_read_data, 32'h89ABCDEF);
        go(1, 0, 3'b001, 32'h101, 0, 32'h80117F22, 0);
`ifdef MISALIGN_TRAP_EN
        chk("mis_lh_cleared", mem_read_data, 32'h0);
`else
        chk("mis_lh_addr", cap_addr, 32'h100);
        chk("mis_lh_result", mem_read_data, 32'h00007F22);
`endif
        go(0, 1, 3'b001, 32'h203, 32'h00005678, 0, 0);
        go(1, 0, 3'b010, 32'h10A, 0, 32'h11223344, 0);
        go(1, 0, 3'b010, 32'h10C, 0, 32'h7E7E7E7E, 0);
        idle(0);
        @(posedge clk); #1;
        ex_mem_load = 1; ex_mem_funct3 = 3'b010; ex_mem_addr = 32'h300;
        e_stall = 1; e_req = 0; e_we = 0; e_addr = 32'h300; e_be = 0;
        @(posedge clk); #1;
        e_req = 1;
        @(posedge clk); #1;
        rst = 1;
        e_req = 0; e_stall = 0;
        #1;
        chk("rst_req_now", {31'd0, dmem_req}, 32'h0);
        chk("rst_stall_now", {31'd0, lsu_stall}, 32'h0);
        chk("rst_result_now", mem_read_data, 32'h0);
        e_mrd = 0;
        @(posedge clk); #1;
        rst = 0; ex_mem_load = 0; dmem_ack = 1; dmem_rdata = 32'h12345678;
        @(posedge clk); #1;
        dmem_ack = 0;
        @(posedge clk); #1;
        chk("late_ack_ignored", mem_read_data, 32'h0);
        @(negedge clk);
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Load/store unit for the MEM stage of the RV32IM 5-stage pipeline. It turns the load/store in MEM into a single request/acknowledge transaction on the data-memory port, generating byte enables and store-data replication. It sign- or zero-extends load data and holds the pipeline with a stall until the access completes. Its `mem_read_data` is the value the MEM/WB register carries into writeback.

## Interface
Parameters: none.

Ports:
- clk  in  1  pipeline clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- ex_mem_load  in  1  load instruction in MEM
- ex_mem_store  in  1  store instruction in MEM; never high together with ex_mem_load
- ex_mem_funct3  in  3  RV32 load/store width code
- ex_mem_addr  in  32  effective byte address (ALU result)
- ex_mem_store_data  in  32  rs2 value for stores
- dmem_req  out  1  request valid (registered)
- dmem_we  out  1  1 = write (registered)
- dmem_addr  out  32  word address, bits [1:0] = 0 (registered)
- dmem_wdata  out  32  replicated store data (registered)
- dmem_be  out  4  byte enables; 0000 for loads (registered)
- dmem_ack  in  1  one-cycle completion pulse from memory
- dmem_rdata  in  32  read word, valid when dmem_ack = 1
- mem_read_data  out  32  extended load result (registered)
- lsu_stall  out  1  freezes IF..MEM and the MEM/WB register
- misalign  out  1  misaligned access flag (see Configuration)

## Operation
- FSM states:
  - IDLE: no access pending.
  - REQ: request issued, waiting for acknowledge.
  - DONE: result is available.
- IDLE with (load | store) and no trap: lsu_stall = 1 combinationally.
  - Next edge: REQ; dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata are registered.
- IDLE with no access: lsu_stall = 0, no request.
- REQ: dmem_req = 1 and lsu_stall = 1. All request outputs are held stable until dmem_ack.
  - On dmem_ack (load): mem_read_data <= formatted dmem_rdata. Next edge goes to DONE and clears dmem_req.
  - On dmem_ack (store): mem_read_data is unchanged.
- DONE: lsu_stall = 0 for exactly one cycle so the pipeline advances. Next edge returns to IDLE.
- dmem_ack in IDLE or DONE is ignored.
- ex_mem_* inputs are stable while lsu_stall = 1, because upstream is frozen.
- Store formatting:
  - SB: be = 0001 << addr[1:0]; wdata = the byte replicated ×4.
  - SH: be = 0011 << (2·addr[1]); wdata = the half replicated ×2.
  - SW: be = 1111.
- Load formatting (byte/half selected by addr[1:0] / addr[1]):
  - 000 LB: sign-extend the byte.
  - 001 LH: sign-extend the half.
  - 010 LW: the full word.
  - 100 LBU: zero-extend the byte.
  - 101 LHU: zero-extend the half.
  - Other codes: treated as a word access.
- Misaligned access: half with addr[0] = 1, or word with addr[1:0] ≠ 00.

## Timing
- Reset values: state IDLE; dmem_req, dmem_we, lsu_stall, misalign = 0; dmem_addr, dmem_wdata, mem_read_data = 0; dmem_be = 0000.
- Minimum access latency: 2 stall cycles.
  - Cycle 0: access presented.
  - Cycle 1: REQ with dmem_ack.
  - Cycle 2: DONE, stall low.
- Each extra wait cycle before dmem_ack adds one stall cycle.
- Back-to-back accesses: the next instruction arrives in IDLE the cycle after DONE, and its request is issued one edge later.
- Reset asserted mid-transaction: immediate return to IDLE and dmem_req drops. The memory side discards the outstanding request.

## Configuration
- MISALIGN_TRAP_EN defined:
  - A misaligned access in IDLE drives misalign = 1 combinationally for that cycle.
  - No request is issued, lsu_stall stays 0, and mem_read_data is cleared to 0 on the next edge.
- MISALIGN_TRAP_EN undefined:
  - misalign is tied 0.
  - Offending low address bits are forced to the access boundary (addr[0] cleared for half, addr[1:0] cleared for word), and the access proceeds normally.

## Structure
- Shared package/include `lsu_defs`:
  - funct3 codes: LB/LH/LW/LBU/LHU and SB/SH/SW.
  - FSM state encodings (2 bits).
- Sub-module `load_formatter`: combinational byte/half select and extension from (funct3, addr[1:0], rdata).

## Test plan
- LW, addr 0x100, dmem_rdata 0xDEADBEEF, ack on first REQ cycle -> stall high 2 cycles; dmem_addr 0x100, dmem_be 0000; mem_read_data 0xDEADBEEF.
- LB addr 0x103, rdata 0x80112233 -> 0xFFFFFF80. LBU same -> 0x00000080. LHU addr 0x102 -> 0x00008011.
- SB addr 0x201, store_data 0x000000A5 -> dmem_be 0010, dmem_wdata 0xA5A5A5A5, dmem_we 1. SH addr 0x202 -> be 1100.
- LW with ack delayed 3 cycles -> dmem_req and outputs stable throughout; stall high 5 cycles; one DONE cycle, then IDLE.
- LH addr 0x101 -> with MISALIGN_TRAP_EN: misalign = 1, no dmem_req, stall 0. Without: dmem_addr 0x100, lower half returned.
- rst pulsed while in REQ -> dmem_req = 0, lsu_stall = 0 and mem_read_data = 0 immediately; a late dmem_ack is ignored.
